dbus_responder: RTL and testbench

- Memory-side responder for the data bus driven by the pipelined core.
- Accepts one data-bus request at a time and backs it with an internal doubleword RAM.
- Returns `addr_ok`/`data_ok` with a fixed, parameterised latency.
- Used as the bench/simulation memory model and as the on-chip scratchpad behind the core's memory stage.

---
 rtl/dbus_responder_if.sv | 22 ++
 rtl/dbus_responder.sv | 109 ++++++++++
 tb/tb_dbus_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_responder_if.sv
// Data-bus request/response bundle between the core's memory stage and its responder.
// The initiator holds a request stable until data_ok; responses are single-cycle pulses.
interface dbus_responder_if;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        dresp_err;

  modport master (
    output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err
  );
endinterface

// File: rtl/dbus_responder.sv
// Single-outstanding data-bus responder backed by a doubleword RAM; addr_ok one cycle after
// acceptance, data_ok LATENCY+1 cycles after; new requests are taken only in IDLE.
module dbus_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  dbus_responder_if.slave   bus
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [63:0] RANGE    = 64'(DEPTH_WORDS) * 64'd8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept, commit;

  logic [63:0] req_addr;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;

  logic        addr_ok_q, data_ok_q, err_q;
  logic [63:0] data_q;

  logic [63:0] mem [DEPTH_WORDS];

  logic [63:0] offset;
  logic        in_range;
  logic        is_wr;
  logic [AW-1:0] idx;

  // Decode works on the latched copy so bus changes after acceptance are harmless.
  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && (offset < RANGE);
  assign idx      = offset[AW+2:3];
  assign is_wr    = |req_strobe;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dreq_valid) begin
          accept   = 1'b1;
          cnt_nx   = CNT_INIT;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit   = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_addr   <= '0;
      req_strobe <= '0;
      req_data   <= '0;
      addr_ok_q  <= 1'b0;
      data_ok_q  <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        req_addr   <= bus.dreq_addr;
        req_strobe <= bus.dreq_strobe;
        req_data   <= bus.dreq_data;
      end
      addr_ok_q <= accept;
      data_ok_q <= commit;
      err_q     <= commit && !in_range;
      data_q    <= (commit && !is_wr && in_range) ? mem[idx] : 64'd0;
    end
  end

  // RAM is deliberately not reset; reset forces IDLE so no commit can occur during it.
  always_ff @(posedge clk) begin
    if (commit && is_wr && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (req_strobe[i]) mem[idx][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

  assign bus.dresp_addr_ok = addr_ok_q;
  assign bus.dresp_data_ok = data_ok_q;
  assign bus.dresp_err     = err_q;
  assign bus.dresp_data    = data_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboarded bench for dbus_responder: a LATENCY=2 instance for the main scenarios
// and a LATENCY=1 instance for the short-latency build.
module tb_dbus_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t sb2[$];
  exp_t sb1[$];

  dbus_responder_if b2();
  dbus_responder_if b1();

  dbus_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .bus(b2)
  );

  dbus_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard
  always @(negedge clk) begin
    exp_t x;
    if (!reset && b2.dresp_data_ok) begin
      tests++;
      if (sb2.size() == 0) begin
        fails++;
        $display("FAIL sb2_unexpected: data_ok with empty scoreboard, data=%h", b2.dresp_data);
      end else begin
        x = sb2.pop_front();
        if (b2.dresp_data !== x.d || b2.dresp_err !== x.e) begin
          fails++;
          $display("FAIL sb2_resp: got data=%h err=%b, want data=%h err=%b",
                   b2.dresp_data, b2.dresp_err, x.d, x.e);
        end
      end
    end
    if (!reset && b1.dresp_data_ok) begin
      tests++;
      if (sb1.size() == 0) begin
        fails++;
        $display("FAIL sb1_unexpected: data_ok with empty scoreboard, data=%h", b1.dresp_data);
      end else begin
        x = sb1.pop_front();
        if (b1.dresp_data !== x.d || b1.dresp_err !== x.e) begin
          fails++;
          $display("FAIL sb1_resp: got data=%h err=%b, want data=%h err=%b",
                   b1.dresp_data, b1.dresp_err, x.d, x.e);
        end
      end
    end
  end

  // Protocol monitor: addr_ok/data_ok strictly alternate
  bit pend2 = 0;
  bit pend1 = 0;
  always @(negedge clk) begin
    if (reset) begin
      pend2 = 0;
      pend1 = 0;
    end else begin
      if (b2.dresp_data_ok || b2.dresp_addr_ok) begin
        tests++;
        if ((b2.dresp_data_ok && !pend2) || (b2.dresp_addr_ok && pend2)) begin
          fails++;
          $display("FAIL proto2: addr_ok=%b data_ok=%b pending=%b", b2.dresp_addr_ok,
                   b2.dresp_data_ok, pend2);
        end
        if (b2.dresp_addr_ok) pend2 = 1;
        if (b2.dresp_data_ok) pend2 = 0;
      end
      if (b1.dresp_data_ok || b1.dresp_addr_ok) begin
        tests++;
        if ((b1.dresp_data_ok && !pend1) || (b1.dresp_addr_ok && pend1)) begin
          fails++;
          $display("FAIL proto1: addr_ok=%b data_ok=%b pending=%b", b1.dresp_addr_ok,
                   b1.dresp_data_ok, pend1);
        end
        if (b1.dresp_addr_ok) pend1 = 1;
        if (b1.dresp_data_ok) pend1 = 0;
      end
    end
  end

  // Drives one request from a negedge and waits (bounded) for its data_ok.
  task automatic issue(input int sel, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, input logic [63:0] ed, input logic ee,
                       input bit hold, output int c0, output int caok, output int cdok);
    exp_t x;
    logic aok, dok;
    x.d = ed;
    x.e = ee;
    if (sel == 1) begin
      sb1.push_back(x);
      b1.dreq_valid = 1'b1; b1.dreq_addr = a; b1.dreq_strobe = s; b1.dreq_data = d;
    end else begin
      sb2.push_back(x);
      b2.dreq_valid = 1'b1; b2.dreq_addr = a; b2.dreq_strobe = s; b2.dreq_data = d;
    end
    c0   = cyc;
    caok = -1;
    cdok = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      aok = (sel == 1) ? b1.dresp_addr_ok : b2.dresp_addr_ok;
      dok = (sel == 1) ? b1.dresp_data_ok : b2.dresp_data_ok;
      if (aok) caok = cyc;
      if (dok) begin
        cdok = cyc;
        break;
      end
    end
    if (cdok < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: no data_ok for addr=%h within 40 cycles", a);
    end
    if (!hold) begin
      if (sel == 1) b1.dreq_valid = 1'b0;
      else          b2.dreq_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (b2.dresp_addr_ok !== 1'b0 || b2.dresp_data_ok !== 1'b0 ||
        b2.dresp_err !== 1'b0 || b2.dresp_data !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs: aok=%b dok=%b err=%b data=%h, want all 0",
               b2.dresp_addr_ok, b2.dresp_data_ok, b2.dresp_err, b2.dresp_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    int c0, ca, cd;
    @(negedge clk);
    issue(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 0, c0, ca, cd);
    tests++;
    if (ca !== c0 + 1 || cd !== c0 + 3) begin
      fails++;
      $display("FAIL wr_timing: aok at +%0d dok at +%0d, want +1 +3", ca - c0, cd - c0);
    end
    @(negedge clk);
    issue(0, 64'h8000_0010, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 0, c0, ca, cd);
    tests++;
    if (ca !== c0 + 1 || cd !== c0 + 3) begin
      fails++;
      $display("FAIL rd_timing: aok at +%0d dok at +%0d, want +1 +3", ca - c0, cd - c0);
    end
  endtask

  task automatic test_partial_strobe();
    int c0, ca, cd;
    @(negedge clk);
    issue(0, 64'h8000_0013, 8'h0C, 64'h0000_0000_AABB_0000, 64'd0, 1'b0, 0, c0, ca, cd);
    @(negedge clk);
    issue(0, 64'h8000_0010, 8'h00, 64'd0, 64'h1122_3344_AABB_7788, 1'b0, 0, c0, ca, cd);
  endtask

  task automatic test_out_of_range();
    int c0, ca, cd;
    @(negedge clk);
    issue(0, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 0, c0, ca, cd);
    @(negedge clk);
    issue(0, 64'h7FFF_FFF8, 8'h00, 64'd0, 64'd0, 1'b1, 0, c0, ca, cd);
    @(negedge clk);
    issue(0, 64'h8000_2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, c0, ca, cd);
    @(negedge clk);
    issue(0, 64'h8000_0000, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, c0, ca, cd);
  endtask

  task automatic test_back_to_back();
    int c0, a1, d1, a2, d2, a3, d3;
    @(negedge clk);
    issue(0, 64'h8000_0008, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 1'b0, 0, c0, a1, d1);
    @(negedge clk);
    issue(0, 64'h8000_0000, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 1, c0, a1, d1);
    issue(0, 64'h8000_0008, 8'h00, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1, c0, a2, d2);
    issue(0, 64'h8000_0010, 8'h00, 64'd0, 64'h1122_3344_AABB_7788, 1'b0, 0, c0, a3, d3);
    tests++;
    if (d2 - d1 !== 4 || d3 - d2 !== 4) begin
      fails++;
      $display("FAIL b2b_spacing: data_ok gaps %0d,%0d want 4,4", d2 - d1, d3 - d2);
    end
    tests++;
    if (a2 !== d1 + 2 || a3 !== d2 + 2) begin
      fails++;
      $display("FAIL b2b_accept: addr_ok at dok+%0d,+%0d want +2,+2", a2 - d1, a3 - d2);
    end
  endtask

  task automatic test_reset_mid_write();
    int c0, ca, cd;
    bit got_aok, saw_dok;
    @(negedge clk);
    issue(0, 64'h8000_0020, 8'hFF, 64'h5, 64'd0, 1'b0, 0, c0, ca, cd);
    @(negedge clk);
    b2.dreq_valid = 1'b1; b2.dreq_addr = 64'h8000_0020;
    b2.dreq_strobe = 8'hFF; b2.dreq_data = 64'hDEAD;
    got_aok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b2.dresp_addr_ok) begin
        got_aok = 1;
        break;
      end
    end
    tests++;
    if (!got_aok) begin
      fails++;
      $display("FAIL rst_accept: addr_ok never seen, got 0 want 1");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (b2.dresp_addr_ok !== 1'b0 || b2.dresp_data_ok !== 1'b0 ||
        b2.dresp_err !== 1'b0 || b2.dresp_data !== 64'd0) begin
      fails++;
      $display("FAIL rst_outputs: aok=%b dok=%b err=%b data=%h, want all 0",
               b2.dresp_addr_ok, b2.dresp_data_ok, b2.dresp_err, b2.dresp_data);
    end
    b2.dreq_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_dok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b2.dresp_data_ok) saw_dok = 1;
    end
    tests++;
    if (saw_dok) begin
      fails++;
      $display("FAIL rst_no_dok: data_ok seen after reset, got 1 want 0");
    end
    issue(0, 64'h8000_0020, 8'h00, 64'd0, 64'h5, 1'b0, 0, c0, ca, cd);
  endtask

  task automatic test_latency1();
    int c0, ca, cd;
    @(negedge clk);
    issue(1, 64'h8000_0000, 8'hFF, 64'hCAFE, 64'd0, 1'b0, 0, c0, ca, cd);
    tests++;
    if (ca !== c0 + 1 || cd !== c0 + 2) begin
      fails++;
      $display("FAIL l1_wr_timing: aok at +%0d dok at +%0d, want +1 +2", ca - c0, cd - c0);
    end
    @(negedge clk);
    issue(1, 64'h8000_0000, 8'h00, 64'd0, 64'hCAFE, 1'b0, 0, c0, ca, cd);
    tests++;
    if (ca !== c0 + 1 || cd !== c0 + 2) begin
      fails++;
      $display("FAIL l1_rd_timing: aok at +%0d dok at +%0d, want +1 +2", ca - c0, cd - c0);
    end
  endtask

  initial begin
    b2.dreq_valid = 1'b0; b2.dreq_addr = '0; b2.dreq_strobe = '0; b2.dreq_data = '0;
    b1.dreq_valid = 1'b0; b1.dreq_addr = '0; b1.dreq_strobe = '0; b1.dreq_data = '0;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_write();
    test_latency1();
    repeat (3) @(negedge clk);
    tests++;
    if (sb2.size() != 0 || sb1.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d/%0d responses outstanding, want 0/0", sb2.size(), sb1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
